serial_full_subtractor: RTL
===========================

Name: serial_full_subtractor

Overview:
- Bit-serial subtractor: computes A - B - bin over WIDTH clock cycles, LSB first.
- Uses one full-subtractor cell and a registered borrow. It is the inverse-direction companion to the combinational full_adder.
- Sits in the arithmetic datapath where area matters more than latency. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk edge; accepted only when busy=0.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result (A - B - bin) mod 2^WIDTH; held until the next completion.
- bout  output  1  final borrow-out; 1 when A < B + bin, unsigned.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers=0, borrow=0, count=0. Outputs take these values immediately, without a clock edge.
- States:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while count < WIDTH-1.
  - SHIFT -> DONE when count = WIDTH-1.
  - DONE -> SHIFT if start=1, otherwise DONE -> IDLE.
- Accept edge (IDLE or DONE with start=1):
  - sa <= a, sb <= b, br <= bin, count <= 0, busy <= 1.
- Each SHIFT edge, with a0=sa[0], b0=sb[0]:
  - d = a0 ^ b0 ^ br.
  - br <= (~a0 & b0) | (~(a0 ^ b0) & br).
  - sa, sb shift right by 1; d shifts into the MSB of the internal result register sr.
  - count <= count + 1.
- Completion edge (last SHIFT edge): diff <= final sr with d included, bout <= final br, done <= 1, busy <= 0.
- Latency: start accepted at edge k -> done=1 and diff/bout valid in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles when back-to-back.
- done is high for exactly one cycle. Any non-completing edge clears it to 0.
- start while busy=1 is ignored; operands and result are unaffected.
- start asserted during the DONE cycle is accepted (back-to-back). done still pulses for one cycle.
- diff/bout change only on a completion edge. Intermediate sr values are never visible on diff.
- rst asserted mid-operation aborts it: all outputs return to their reset values and no done pulse is issued. The first start after rst deasserts begins a fresh operation.
- count width is clog2(WIDTH)+1. No wrap is possible because count resets on every accept.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, bin=0, one-cycle start -> busy high for 8 cycles; done pulse at cycle 9; diff=8'h37, bout=0.
- a=8'h10, b=8'h20, bin=0 -> diff=8'hF0, bout=1. Then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
- a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, bout=0. Then a=8'h80, b=8'h01, bin=1 -> diff=8'h7E, bout=0.
- Start a=8'h09, b=8'h04; pulse start with a=8'hAA, b=8'h55 at cycle 3 -> ignored; diff=8'h05 at done; no extra done pulse.
- Back-to-back: assert start in the DONE cycle with a=8'h03, b=8'h05 -> first result is 8'h05; second done exactly 9 cycles later with diff=8'hFE, bout=1.
- Reset mid-op: start a=8'h40, b=8'h01; assert rst at cycle 4 -> immediately busy=0, done=0, diff=0, bout=0; no done pulse. After release, start a=8'h40, b=8'h01 -> diff=8'h3F.

Source files
------------

// File: rtl/serial_full_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// start is sampled only while busy is low; done pulses for one cycle when diff/bout update.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial A - B - bin, LSB first, one full-subtractor cell and a registered borrow.
// A subtraction takes WIDTH SHIFT cycles; a start in the DONE cycle chains the next operation.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_full_subtractor_if.slave   bus,
    output logic [1:0]                state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   sr_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;

    logic               d_bit;
    logic               br_d;
    logic [WIDTH-1:0]   sr_d;
    logic               last_shift;

    always_comb begin
        d_bit      = sa_q[0] ^ sb_q[0] ^ br_q;
        br_d       = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        sr_d       = {d_bit, sr_q[WIDTH-1:1]};
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= SHIFT;
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        sr_q    <= '0;
                        br_q    <= bus.bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    // Shift registers advance every SHIFT cycle; the result bus only moves on the last one.
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sr_q  <= sr_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        state_q <= DONE;
                        diff_q  <= sr_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign state_o  = state_q;

endmodule
